rx_link_ctrl: RTL and testbench
===============================

Name: rx_link_ctrl

Overview:
Receive-side link training and sequencing controller for the 2-lane PHY RX path. It sits between the two serial-to-parallel deserialisers and the 8b-to-32b converters. It watches each lane's recovered byte stream for COM symbols and declares per-lane symbol lock. It checks that the lanes are deskewed, drives sincronizar_bus into the lane-0 8b-to-32b converter, and reports link state and an error count.

Parameters:
COM_SYM, 8'hBC, K28.5 comma byte value used for lock detection
COM_REQ, 4, consecutive valid COM bytes required per lane to declare lock (1..15)
LOSS_CYC, 8, consecutive cycles of valid low on a locked lane that drop its lock (1..255)
ALIGN_TO, 16, max cycles in ALIGN before timing out back to SEARCH (1..255)

Ports:
clk_4f  input  1  byte-rate clock, the only clock; all logic on rising edge
reset  input  1  synchronous, active-high; sampled on clk_4f
data_0  input  8  lane 0 recovered byte from deserialiser
valid_0  input  1  lane 0 byte valid
data_1  input  8  lane 1 recovered byte from deserialiser
valid_1  input  1  lane 1 byte valid
sincronizar_bus  output  1  sync enable to the lane-0 8b-to-32b converter
link_active  output  1  link trained, data path live
lane_lock  output  2  per-lane symbol lock, bit n = lane n
state  output  2  FSM state: 0 IDLE, 1 SEARCH, 2 ALIGN, 3 ACTIVE
err_count  output  8  saturating count of link-down/skew/timeout events

Behaviour:
- All outputs are registered. While reset=1 at an edge: state=IDLE, lane_lock=0, sincronizar_bus=0, link_active=0, err_count=0, and all internal counters are cleared. Reset mid-operation aborts any state immediately on that edge.
- Per-lane COM counter ccnt_n (4b):
  - valid_n && data_n==COM_SYM increments ccnt_n, saturating at COM_REQ.
  - valid_n && data_n!=COM_SYM with lane unlocked sets ccnt_n=0.
  - valid_n=0 holds ccnt_n.
  - lane_lock[n] rises on the edge after the COM_REQ-th consecutive COM is sampled.
- Loss counter lcnt_n (8b), active only while locked:
  - Increments each cycle valid_n=0 and resets to 0 on valid_n=1.
  - When lcnt_n reaches LOSS_CYC, lane_lock[n] clears on that edge and ccnt_n resets to 0.
  - Non-COM valid bytes never clear an established lock.
- FSM:
  - IDLE -> SEARCH unconditionally on the first edge after reset deasserts.
  - SEARCH -> ALIGN when lane_lock==2'b11.
  - ALIGN: tcnt counts cycles from entry.
    - Both valid and both non-COM in the same cycle -> ACTIVE. Deskew is confirmed and sincronizar_bus=1 from the same edge.
    - Both valid, exactly one lane non-COM -> skew error: SEARCH, err_count+1, both locks and counters cleared.
    - tcnt reaches ALIGN_TO -> SEARCH, err_count+1, locks cleared.
    - Either lock lost -> SEARCH, err_count+1.
    - Skew takes priority over timeout when both occur in the same cycle.
  - ACTIVE: sincronizar_bus=1, link_active=1. Any lane_lock bit falling -> SEARCH on the same edge the lock drops, outputs low, err_count+1. The other lane's lock is cleared too.
  - SEARCH: a lock falling returns that lane to counting; no error is counted.
- err_count saturates at 8'hFF and never wraps. It clears only on reset.
- Outputs in each state:
  - link_active=1 only in ACTIVE.
  - sincronizar_bus=1 only in ACTIVE.
  - state output mirrors the internal state register.
- Latency: a clean entry from SEARCH with both lanes synchronous takes COM_REQ COM cycles + 1 (lock) + 1 (ALIGN) + first data cycle to reach ACTIVE.

Test Plan:
1. Reset held 3 cycles, then released, lanes idle (valid=0) -> state 0 then 1 and stays 1; all outputs 0; err_count=0.
2. Both lanes 4x 8'hBC valid then 8'h5A/8'hA5 simultaneously -> lane_lock=2'b11 after 4th COM; state 2; next non-COM pair gives state 3, link_active=1, sincronizar_bus=1.
3. Lane 1 delayed one byte (lane 0 data 8'h11 while lane 1 still 8'hBC) in ALIGN -> state 1, err_count=1, lane_lock=0.
4. In ACTIVE, valid_0 low 8 consecutive cycles -> lane_lock[0]=0 and state 1 on the 8th; link_active=0; err_count incremented; 7 low cycles then high -> stays ACTIVE.
5. In ALIGN with both lanes sending only COM for 16 cycles -> timeout to SEARCH, err_count+1. Force 300 error events -> err_count holds 8'hFF.
6. Reset asserted while ACTIVE -> next edge state 0, all outputs 0, err_count 0. 3x COM then 1 non-COM on lane 0 -> ccnt_0 resets and no lock.

Source files
------------

// File: rtl/rx_link_ctrl.sv
// rx_link_ctrl: per-lane COM lock, lane deskew check and link sequencing for the 2-lane RX path.
// Enables the lane-0 8b-to-32b converter once both lanes are locked and start data on the same byte.
module rx_link_ctrl #(
  parameter logic [7:0]  COM_SYM  = 8'hBC,
  parameter int unsigned COM_REQ  = 4,
  parameter int unsigned LOSS_CYC = 8,
  parameter int unsigned ALIGN_TO = 16
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic [7:0] data_0,
  input  logic       valid_0,
  input  logic [7:0] data_1,
  input  logic       valid_1,
  output logic       sincronizar_bus,
  output logic       link_active,
  output logic [1:0] lane_lock,
  output logic [1:0] state,
  output logic [7:0] err_count
);
  // state  | meaning
  // IDLE   | first cycle out of reset
  // SEARCH | lanes hunting for COM_REQ consecutive COM bytes
  // ALIGN  | both lanes locked, waiting for the first common data byte
  // ACTIVE | lanes deskewed, data path live
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    ALIGN  = 2'd2,
    ACTIVE = 2'd3
  } state_t;

  localparam logic [3:0] COM_REQ_C  = 4'(COM_REQ);
  localparam logic [7:0] LOSS_CYC_C = 8'(LOSS_CYC);
  localparam logic [7:0] ALIGN_TO_C = 8'(ALIGN_TO);

  state_t     st, st_nx;
  logic [3:0] ccnt    [2];
  logic [3:0] ccnt_nx [2];
  logic [7:0] lcnt    [2];
  logic [7:0] lcnt_nx [2];
  logic [1:0] lock_nx;
  logic [1:0] valid_v;
  logic [1:0] com_v;
  logic [1:0] drop;
  logic [7:0] tcnt;
  logic       err_evt;

  assign valid_v = {valid_1, valid_0};
  assign com_v   = {data_1 == COM_SYM, data_0 == COM_SYM};

  // lcnt counts down from LOSS_CYC while a locked lane is idle; reaching 1 on an idle cycle drops lock
  assign drop[0] = lane_lock[0] & ~valid_v[0] & (lcnt[0] == 8'd1);
  assign drop[1] = lane_lock[1] & ~valid_v[1] & (lcnt[1] == 8'd1);

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      ccnt_nx[n] = ccnt[n];
      lcnt_nx[n] = LOSS_CYC_C;
      lock_nx[n] = lane_lock[n] | (ccnt[n] == COM_REQ_C);
      if (valid_v[n] && com_v[n]) begin
        if (ccnt[n] != COM_REQ_C) ccnt_nx[n] = ccnt[n] + 4'd1;
      end else if (valid_v[n] && !lane_lock[n]) begin
        ccnt_nx[n] = '0;
      end
      if (lane_lock[n] && !valid_v[n]) lcnt_nx[n] = lcnt[n] - 8'd1;
      if (drop[n]) begin
        ccnt_nx[n] = '0;
        lcnt_nx[n] = LOSS_CYC_C;
        lock_nx[n] = 1'b0;
      end
    end
  end

  always_comb begin
    st_nx   = st;
    err_evt = 1'b0;
    case (st)
      IDLE:   st_nx = SEARCH;
      SEARCH: if (lane_lock == 2'b11 && drop == 2'b00) st_nx = ALIGN;
      ALIGN: begin
        // skew is checked before the timeout so a late lane is reported as skew
        if (drop != 2'b00)                               err_evt = 1'b1;
        else if (valid_v == 2'b11 && com_v == 2'b00)     st_nx   = ACTIVE;
        else if (valid_v == 2'b11 && com_v != 2'b11)     err_evt = 1'b1;
        else if (tcnt == 8'd1)                           err_evt = 1'b1;
      end
      ACTIVE: if (drop != 2'b00) err_evt = 1'b1;
      default: st_nx = IDLE;
    endcase
    if (err_evt) st_nx = SEARCH;
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      st              <= IDLE;
      lane_lock       <= '0;
      tcnt            <= ALIGN_TO_C;
      err_count       <= '0;
      link_active     <= 1'b0;
      sincronizar_bus <= 1'b0;
      for (int n = 0; n < 2; n++) begin
        ccnt[n] <= '0;
        lcnt[n] <= LOSS_CYC_C;
      end
    end else begin
      st              <= st_nx;
      link_active     <= (st_nx == ACTIVE);
      sincronizar_bus <= (st_nx == ACTIVE);
      tcnt            <= (st == ALIGN) ? tcnt - 8'd1 : ALIGN_TO_C;
      if (err_evt && err_count != 8'hFF) err_count <= err_count + 8'd1;
      lane_lock <= err_evt ? 2'b00 : lock_nx;
      for (int n = 0; n < 2; n++) begin
        ccnt[n] <= err_evt ? 4'd0 : ccnt_nx[n];
        lcnt[n] <= err_evt ? LOSS_CYC_C : lcnt_nx[n];
      end
    end
  end

  assign state = st;

endmodule

// File: tb/tb_rx_link_ctrl.sv
// Testbench for rx_link_ctrl: directed vector table, hand-written corner sequences,
// then randomized traffic compared against a cycle-level reference model.
module tb_rx_link_ctrl;
  localparam logic [7:0] COM      = 8'hBC;
  localparam int         COM_REQ  = 4;
  localparam int         LOSS_CYC = 8;
  localparam int         ALIGN_TO = 16;

  logic       clk_4f = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_0 = '0, data_1 = '0;
  logic       valid_0 = 1'b0, valid_1 = 1'b0;
  logic       sincronizar_bus, link_active;
  logic [1:0] lane_lock, state;
  logic [7:0] err_count;

  rx_link_ctrl dut (
    .clk_4f(clk_4f), .reset(reset),
    .data_0(data_0), .valid_0(valid_0),
    .data_1(data_1), .valid_1(valid_1),
    .sincronizar_bus(sincronizar_bus), .link_active(link_active),
    .lane_lock(lane_lock), .state(state), .err_count(err_count)
  );

  always #5 clk_4f = ~clk_4f;

  int checks = 0;
  int failures = 0;

  // reference model: run lengths and event counts as plain integers
  int m_run [2];
  int m_low [2];
  bit m_lock[2];
  int m_mode, m_acyc, m_errs;

  typedef struct {
    logic rst; logic v0; logic [7:0] d0; logic v1; logic [7:0] d1;
    logic [1:0] st; logic [1:0] lk; logic act; logic [7:0] err;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic rst, input logic v0, input logic [7:0] d0,
                     input logic v1, input logic [7:0] d1, input logic [1:0] st,
                     input logic [1:0] lk, input logic act, input logic [7:0] err);
    vec_t t;
    t.rst = rst; t.v0 = v0; t.d0 = d0; t.v1 = v1; t.d1 = d1;
    t.st = st; t.lk = lk; t.act = act; t.err = err;
    tbl.push_back(t);
  endtask

  task automatic model_step(input logic rst, input logic v0, input logic [7:0] d0,
                            input logic v1, input logic [7:0] d1);
    bit v[2], c[2], drop[2], nlock[2], err;
    v[0] = v0; v[1] = v1; c[0] = (d0 == COM); c[1] = (d1 == COM);
    if (rst) begin
      m_mode = 0; m_acyc = 0; m_errs = 0;
      for (int n = 0; n < 2; n++) begin m_run[n] = 0; m_low[n] = 0; m_lock[n] = 0; end
      return;
    end
    for (int n = 0; n < 2; n++) drop[n] = m_lock[n] && !v[n] && (m_low[n] + 1 >= LOSS_CYC);
    err = 0;
    case (m_mode)
      0: m_mode = 1;
      1: if (m_lock[0] && m_lock[1] && !drop[0] && !drop[1]) begin m_mode = 2; m_acyc = 0; end
      2: begin
        m_acyc++;
        if (drop[0] || drop[1]) err = 1;
        else if (v[0] && v[1] && !c[0] && !c[1]) m_mode = 3;
        else if (v[0] && v[1] && (c[0] != c[1])) err = 1;
        else if (m_acyc >= ALIGN_TO) err = 1;
      end
      3: if (drop[0] || drop[1]) err = 1;
      default: m_mode = 0;
    endcase
    for (int n = 0; n < 2; n++) begin
      nlock[n] = m_lock[n] || (m_run[n] >= COM_REQ);
      m_low[n] = (m_lock[n] && !v[n]) ? m_low[n] + 1 : 0;
      if (v[n] && c[n]) m_run[n]++;
      else if (v[n] && !m_lock[n]) m_run[n] = 0;
      m_lock[n] = nlock[n];
      if (drop[n] || err) begin m_lock[n] = 0; m_run[n] = 0; m_low[n] = 0; end
    end
    if (err) begin m_mode = 1; m_errs++; end
  endtask

  task automatic drive(input logic rst, input logic v0, input logic [7:0] d0,
                       input logic v1, input logic [7:0] d1);
    @(negedge clk_4f);
    reset = rst; valid_0 = v0; data_0 = d0; valid_1 = v1; data_1 = d1;
    @(posedge clk_4f);
    model_step(rst, v0, d0, v1, d1);
    #1;
  endtask

  task automatic check_out(input string name, input logic [1:0] st, input logic [1:0] lk,
                           input logic act, input logic [7:0] err);
    checks++;
    if (state !== st || lane_lock !== lk || link_active !== act ||
        sincronizar_bus !== act || err_count !== err) begin
      failures++;
      $display("FAIL %s: got state=%0d lock=%b link_active=%b sync=%b err=%0d; want state=%0d lock=%b link_active=sync=%b err=%0d",
               name, state, lane_lock, link_active, sincronizar_bus, err_count, st, lk, act, err);
    end
  endtask

  task automatic check_model(input string name);
    check_out(name, 2'(m_mode), {m_lock[1], m_lock[0]}, (m_mode == 3),
              (m_errs > 255) ? 8'hFF : 8'(m_errs));
  endtask

  int         prof, thr, comw;
  logic       r, v0, v1;
  logic [7:0] d0, d1;

  initial begin
    // reset, clean training, ACTIVE loss boundary, skew in ALIGN
    for (int i = 0; i < 3; i++) add(1, 0, 8'h00, 0, 8'h00, 0, 2'b00, 0, 0);
    for (int i = 0; i < 2; i++) add(0, 0, 8'h00, 0, 8'h00, 1, 2'b00, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 1, COM, 1, COM, 1, 2'b00, 0, 0);
    add(0, 1, 8'h5A, 1, 8'hA5, 1, 2'b11, 0, 0);
    add(0, 1, 8'h5A, 1, 8'hA5, 2, 2'b11, 0, 0);
    add(0, 1, 8'h5A, 1, 8'hA5, 3, 2'b11, 1, 0);
    add(0, 1, 8'h5A, 1, 8'hA5, 3, 2'b11, 1, 0);
    for (int i = 0; i < 7; i++) add(0, 0, 8'h5A, 1, 8'hA5, 3, 2'b11, 1, 0);
    add(0, 1, 8'h5A, 1, 8'hA5, 3, 2'b11, 1, 0);
    for (int i = 0; i < 7; i++) add(0, 0, 8'h5A, 1, 8'hA5, 3, 2'b11, 1, 0);
    add(0, 0, 8'h5A, 1, 8'hA5, 1, 2'b00, 0, 1);
    for (int i = 0; i < 4; i++) add(0, 1, COM, 1, COM, 1, 2'b00, 0, 1);
    add(0, 1, COM, 1, COM, 1, 2'b11, 0, 1);
    add(0, 1, COM, 1, COM, 2, 2'b11, 0, 1);
    add(0, 1, 8'h11, 1, COM, 1, 2'b00, 0, 2);
    add(0, 1, COM, 1, COM, 1, 2'b00, 0, 2);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1);
      check_out($sformatf("vec%0d", i), tbl[i].st, tbl[i].lk, tbl[i].act, tbl[i].err);
    end

    // ALIGN timeout after exactly ALIGN_TO cycles of COM-only traffic
    drive(1, 0, 8'h00, 0, 8'h00);
    drive(0, 0, 8'h00, 0, 8'h00);
    for (int i = 0; i < 6; i++) drive(0, 1, COM, 1, COM);
    check_out("align_entry", 2, 2'b11, 0, 0);
    for (int i = 0; i < ALIGN_TO - 1; i++) drive(0, 1, COM, 1, COM);
    check_out("align_before_to", 2, 2'b11, 0, 0);
    drive(0, 1, COM, 1, COM);
    check_out("align_timeout", 1, 2'b00, 0, 1);

    // repeated skew events until err_count saturates
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 6; k++) drive(0, 1, COM, 1, COM);
      drive(0, 1, 8'h11, 1, COM);
      if (i == 252) check_out("err_254", 1, 2'b00, 0, 8'hFE);
      if (i == 253) check_out("err_255", 1, 2'b00, 0, 8'hFF);
    end
    check_out("err_saturated", 1, 2'b00, 0, 8'hFF);

    // reset while ACTIVE, then lock boundary on lane 0
    for (int i = 0; i < 4; i++) drive(0, 1, COM, 1, COM);
    for (int i = 0; i < 3; i++) drive(0, 1, 8'h5A, 1, 8'hA5);
    check_out("active_again", 3, 2'b11, 1, 8'hFF);
    drive(1, 1, 8'h5A, 1, 8'hA5);
    check_out("reset_in_active", 0, 2'b00, 0, 0);
    drive(0, 0, 8'h00, 0, 8'h00);
    check_out("post_reset_search", 1, 2'b00, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, COM, 0, 8'h00);
    drive(0, 1, 8'h33, 0, 8'h00);
    for (int i = 0; i < 4; i++) drive(0, 0, 8'h00, 0, 8'h00);
    check_out("three_com_no_lock", 1, 2'b00, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, COM, 0, 8'h00);
    check_out("fourth_com_sampled", 1, 2'b00, 0, 0);
    drive(0, 0, 8'h00, 0, 8'h00);
    check_out("lane0_lock", 1, 2'b01, 0, 0);

    // randomized traffic against the reference model
    drive(1, 0, 8'h00, 0, 8'h00);
    check_model("rand_reset");
    for (int seg = 0; seg < 60; seg++) begin
      prof = $urandom_range(0, 3);
      thr  = (prof == 3) ? 6 : 15;
      comw = (prof == 0) ? 3 : (prof == 2) ? 1 : 2;
      for (int k = 0; k < 30; k++) begin
        r  = ($urandom_range(0, 299) == 0);
        v0 = ($urandom_range(0, 15) < thr);
        v1 = ($urandom_range(0, 15) < thr);
        d0 = ($urandom_range(0, 3) < comw) ? COM : 8'($urandom);
        if ($urandom_range(0, 1) == 1) d1 = d0;
        else d1 = ($urandom_range(0, 3) < comw) ? COM : 8'($urandom);
        drive(r, v0, d0, v1, d1);
        check_model($sformatf("rand%0d_%0d", seg, k));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
